mpc_vsub_row_sched: RTL and testbench
=====================================

# mpc_vsub_row_sched

Round-robin scheduler that shares one `vsub_row` saturating-subtract pipeline (f1[i] = sat32(e[i] − temp[i]), i = 0..7) between two requesters in the MPC dense-constraint stage. It runs a start/ready/done handshake with each requester and with the pipeline. It steers the pipeline's `temp_V` read port and `f1_V` write port to the granted requester's memories, and it guarantees that exactly one requester owns the pipeline from grant until done.

## Interface
- `DW`, 32, data width of temp/f1 words
- `AW`, 3, memory address width (8-entry row)
- `ap_clk`  in  1  clock, rising edge
- `ap_rst`  in  1  reset, asynchronous, active-high
- `req_start`  in  2  per-requester start, level, held until matching `req_done`
- `req_ready`  out  2  one-cycle pulse: request accepted (pipeline took `sub_start`)
- `req_done`  out  2  one-cycle pulse: row written for that requester
- `busy`  out  1  scheduler not in IDLE
- `sub_start`  out  1  to pipeline `ap_start`
- `sub_ready`, `sub_done`, `sub_idle`  in  1 each  from pipeline
- `sub_temp_address0` [AW], `sub_temp_ce0`  in  pipeline temp read port
- `sub_temp_q0`  out  DW  muxed read data to pipeline
- `sub_f1_address0` [AW], `sub_f1_ce0`, `sub_f1_we0`, `sub_f1_d0` [DW]  in  pipeline write port
- `r0_temp_address0`/`r1_temp_address0` out AW, `r0_temp_ce0`/`r1_temp_ce0` out 1, `r0_temp_q0`/`r1_temp_q0` in DW
- `r0_f1_address0`/`r1_f1_address0` out AW, `r0_f1_ce0`/`r1_f1_ce0`/`r0_f1_we0`/`r1_f1_we0` out 1, `r0_f1_d0`/`r1_f1_d0` out DW

## Operation
- States: IDLE, START, RUN, DONE. Register `gnt` (1 bit) names the owner. Register `last` holds the last-served index.
- IDLE: if any `req_start` is high, choose the winner and go to START.
  - Winner when both request: `~last`. Otherwise the sole requester.
- START: `sub_start`=1.
  - On `sub_ready`=1: pulse `req_ready[gnt]`, set `last`=`gnt`, go to RUN.
  - If `sub_done` is also 1 in the same cycle, go straight to DONE.
- RUN: `sub_start`=0. Wait for `sub_done`=1, then go to DONE.
- DONE: pulse `req_done[gnt]` for 1 cycle, then go to IDLE.
- Port steering, active only in START and RUN:
  - addresses, `d0` and `q0` route to/from requester `gnt`.
  - `ce`/`we` of the non-granted requester are forced to 0.
  - In IDLE and DONE, all `r*_ce0`/`r*_we0` are 0 and `sub_temp_q0` is 0.
- Addresses and `d0` to a non-granted requester are don't-care; they are driven with the pipeline value to avoid extra muxes.
- A `req_start` dropped before grant is ignored. A `req_start` dropped after grant does not abort the run.
- The scheduler does no arithmetic. The pipeline result width is 33-bit, saturated to DW: +ovf gives 0x7FFFFFFF, −ovf gives 0x80000000.

## Timing
- Reset values:
  - state IDLE, `gnt`=0, `last`=1 (requester 0 wins the first tie).
  - All outputs 0.
- Reset asserted mid-run:
  - Immediate return to IDLE, all enables 0.
  - No `req_done` is issued. The requester must re-request.
- Latency from `req_start` (IDLE) to `sub_start`: 1 cycle.
- For an 8-element row with the 2-stage pipeline:
  - `sub_done` follows `sub_start` by 9 cycles.
  - `req_done` follows `sub_done` by 1 cycle.
  - Total 11–12 cycles per row.
- Back-to-back: DONE→IDLE→START adds 2 idle cycles between rows. The other requester gets the next grant when both are pending.
- Combinational paths:
  - `sub_temp_q0` is combinational from `r*_temp_q0`.
  - `r*_f1_*` are combinational from `sub_f1_*`.
  - No added pipeline latency on memory ports.

## Configuration
- `MPC_VSUB_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority. Requester 0 always wins ties and `last` is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Single request: hold `req_start`=2'b01, r0_temp = {0..7}, e = ROM row.
  - `sub_start` 1 cycle later.
  - r0 f1[i] = e[i] − i.
  - `req_done`=2'b01 one pulse; r1 ce/we never high.
- Tie: `req_start`=2'b11 from reset.
  - r0 served first, then r1.
  - With `req_start` held at 2'b11, the grant order is 0,1,0,1.
  - With the macro defined, the grant order is 0,0,0.
- Saturation passthrough: r1_temp[3] = 0x80000000, e[3] = 0x000FFFFF.
  - r1 f1[3] = 0x7FFFFFFF.
  - r1_temp[5] = 0x7FFFFFFF, e[5] = 0 gives f1[5] = 0x80000001, no saturation.
- Late arrival: r1 raises `req_start` while r0 is in RUN.
  - r1 is granted only after r0's DONE.
  - No r1 memory access during r0's run.
- Reset mid-run: assert `ap_rst` 4 cycles after `sub_start`.
  - All outputs 0 asynchronously.
  - No `req_done`.
  - After release, a fresh request completes normally.
- Abandoned request: `req_start`=2'b10 pulsed for 1 cycle while busy with r0.
  - No r1 grant after r0 completes.

Source files
------------

// File: rtl/mpc_vsub_row_sched.sv
// Owner scheduler that shares one vsub_row subtract pipeline between two requesters.
// Define MPC_VSUB_SCHED_FIXED_PRIO_EN for fixed priority; the default build is round-robin.
module mpc_vsub_row_sched #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          ap_clk,
    input  logic          ap_rst,

    input  logic [1:0]    req_start,
    output logic [1:0]    req_ready,
    output logic [1:0]    req_done,
    output logic          busy,

    output logic          sub_start,
    input  logic          sub_ready,
    input  logic          sub_done,
    input  logic          sub_idle,
    input  logic [AW-1:0] sub_temp_address0,
    input  logic          sub_temp_ce0,
    output logic [DW-1:0] sub_temp_q0,
    input  logic [AW-1:0] sub_f1_address0,
    input  logic          sub_f1_ce0,
    input  logic          sub_f1_we0,
    input  logic [DW-1:0] sub_f1_d0,

    output logic [AW-1:0] r0_temp_address0,
    output logic          r0_temp_ce0,
    input  logic [DW-1:0] r0_temp_q0,
    output logic [AW-1:0] r0_f1_address0,
    output logic          r0_f1_ce0,
    output logic          r0_f1_we0,
    output logic [DW-1:0] r0_f1_d0,

    output logic [AW-1:0] r1_temp_address0,
    output logic          r1_temp_ce0,
    input  logic [DW-1:0] r1_temp_q0,
    output logic [AW-1:0] r1_f1_address0,
    output logic          r1_f1_ce0,
    output logic          r1_f1_we0,
    output logic [DW-1:0] r1_f1_d0
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       gnt;
    logic       gnt_nxt;
    logic       winner;
    logic       accept;
    logic       finish;
    logic       active;
    logic       sel0;
    logic       sel1;

    assign accept = (state == ST_START) && sub_ready;
    assign finish = (state == ST_DONE);

`ifndef MPC_VSUB_SCHED_FIXED_PRIO_EN
    // Resets to 1 so requester 0 wins the first tie after reset.
    logic last;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= gnt;
        end
    end

    assign winner = (&req_start) ? ~last : req_start[1];
`else
    assign winner = ~req_start[0];
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        gnt_nxt   = gnt;
        case (state)
            ST_IDLE: begin
                if (|req_start) begin
                    gnt_nxt   = winner;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (sub_ready) begin
                    state_nxt = sub_done ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (sub_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (ap_rst) begin
            state <= ST_IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign sub_start = (state == ST_START);
    assign req_ready = {accept & gnt, accept & ~gnt};
    assign req_done  = {finish & gnt, finish & ~gnt};

    // Memory ports are steered only while the pipeline is owned; addresses and data fan out unmuxed.
    assign active = (state == ST_START) || (state == ST_RUN);
    assign sel0   = active & ~gnt;
    assign sel1   = active &  gnt;

    assign r0_temp_address0 = sub_temp_address0;
    assign r0_temp_ce0      = sel0 & sub_temp_ce0;
    assign r0_f1_address0   = sub_f1_address0;
    assign r0_f1_ce0        = sel0 & sub_f1_ce0;
    assign r0_f1_we0        = sel0 & sub_f1_we0;
    assign r0_f1_d0         = sub_f1_d0;

    assign r1_temp_address0 = sub_temp_address0;
    assign r1_temp_ce0      = sel1 & sub_temp_ce0;
    assign r1_f1_address0   = sub_f1_address0;
    assign r1_f1_ce0        = sel1 & sub_f1_ce0;
    assign r1_f1_we0        = sel1 & sub_f1_we0;
    assign r1_f1_d0         = sub_f1_d0;

    assign sub_temp_q0 = sel0 ? r0_temp_q0 :
                         sel1 ? r1_temp_q0 : '0;

    // The pipeline must be mid-row whenever the scheduler believes it is running.
    a_run_not_idle: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (state == ST_RUN) |-> !sub_idle);

    a_single_owner: assert property (@(posedge ap_clk) disable iff (ap_rst)
        !((r0_temp_ce0 | r0_f1_ce0) && (r1_temp_ce0 | r1_f1_ce0)));

endmodule

// File: tb/tb_mpc_vsub_row_sched.sv
// Randomized bench for mpc_vsub_row_sched with a behavioural pipeline, memories and a
// grant-order / row-result reference model.
module tb_mpc_vsub_row_sched;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [1:0]    req_start;
    logic [1:0]    req_ready;
    logic [1:0]    req_done;
    logic          busy;
    logic          sub_start;
    logic          sub_ready;
    logic          sub_done;
    logic          sub_idle;
    logic [AW-1:0] sub_temp_address0;
    logic          sub_temp_ce0;
    logic [DW-1:0] sub_temp_q0;
    logic [AW-1:0] sub_f1_address0;
    logic          sub_f1_ce0;
    logic          sub_f1_we0;
    logic [DW-1:0] sub_f1_d0;
    logic [AW-1:0] r0_temp_address0, r1_temp_address0;
    logic          r0_temp_ce0, r1_temp_ce0;
    logic [DW-1:0] r0_temp_q0, r1_temp_q0;
    logic [AW-1:0] r0_f1_address0, r1_f1_address0;
    logic          r0_f1_ce0, r1_f1_ce0, r0_f1_we0, r1_f1_we0;
    logic [DW-1:0] r0_f1_d0, r1_f1_d0;

    always #5 ap_clk = ~ap_clk;

    mpc_vsub_row_sched #(.DW(DW), .AW(AW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_start(req_start), .req_ready(req_ready), .req_done(req_done), .busy(busy),
        .sub_start(sub_start), .sub_ready(sub_ready), .sub_done(sub_done), .sub_idle(sub_idle),
        .sub_temp_address0(sub_temp_address0), .sub_temp_ce0(sub_temp_ce0), .sub_temp_q0(sub_temp_q0),
        .sub_f1_address0(sub_f1_address0), .sub_f1_ce0(sub_f1_ce0), .sub_f1_we0(sub_f1_we0),
        .sub_f1_d0(sub_f1_d0),
        .r0_temp_address0(r0_temp_address0), .r0_temp_ce0(r0_temp_ce0), .r0_temp_q0(r0_temp_q0),
        .r0_f1_address0(r0_f1_address0), .r0_f1_ce0(r0_f1_ce0), .r0_f1_we0(r0_f1_we0),
        .r0_f1_d0(r0_f1_d0),
        .r1_temp_address0(r1_temp_address0), .r1_temp_ce0(r1_temp_ce0), .r1_temp_q0(r1_temp_q0),
        .r1_f1_address0(r1_f1_address0), .r1_f1_ce0(r1_f1_ce0), .r1_f1_we0(r1_f1_we0),
        .r1_f1_d0(r1_f1_d0)
    );

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        if (d > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (d < -64'sd2147483648) return 32'h8000_0000;
        return d[31:0];
    endfunction

    // Requester memories (synchronous read) and the pipeline's e row.
    logic [DW-1:0] e_rom    [8];
    logic [DW-1:0] temp_mem [2][8];
    logic [DW-1:0] f1_mem   [2][8];

    always @(posedge ap_clk) begin
        if (r0_temp_ce0) r0_temp_q0 <= temp_mem[0][r0_temp_address0];
        if (r1_temp_ce0) r1_temp_q0 <= temp_mem[1][r1_temp_address0];
        if (r0_f1_ce0 && r0_f1_we0) f1_mem[0][r0_f1_address0] <= r0_f1_d0;
        if (r1_f1_ce0 && r1_f1_we0) f1_mem[1][r1_f1_address0] <= r1_f1_d0;
    end

    // Pipeline stand-in: reads cycles 1..8, writes cycles 2..9, done on cycle 9.
    int cnt;
    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) cnt <= 0;
        else if (cnt == 0) begin
            if (sub_start) cnt <= 1;
        end
        else if (cnt == 9) cnt <= 0;
        else cnt <= cnt + 1;
    end

    assign sub_ready         = sub_start && (cnt == 0);
    assign sub_idle          = (cnt == 0);
    assign sub_done          = (cnt == 9);
    assign sub_temp_ce0      = (cnt >= 1) && (cnt <= 8);
    assign sub_temp_address0 = sub_temp_ce0 ? AW'(cnt - 1) : '0;
    assign sub_f1_ce0        = (cnt >= 2) && (cnt <= 9);
    assign sub_f1_we0        = sub_f1_ce0;
    assign sub_f1_address0   = sub_f1_ce0 ? AW'(cnt - 2) : '0;
    assign sub_f1_d0         = sub_f1_ce0 ? sat_sub(e_rom[sub_f1_address0], sub_temp_q0) : '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ownership monitor: who holds the pipeline, and any access by a non-owner.
    int owner  = -1;
    int viol   = 0;
    int grants = 0;
    int dones  = 0;

    always @(negedge ap_clk) begin
        if ((owner != 0) && (r0_temp_ce0 || r0_f1_ce0 || r0_f1_we0)) viol <= viol + 1;
        if ((owner != 1) && (r1_temp_ce0 || r1_f1_ce0 || r1_f1_we0)) viol <= viol + 1;
        if ((!busy || req_done != 2'b00) && sub_temp_q0 != '0) viol <= viol + 1;
        if (ap_rst) owner <= -1;
        else if (req_ready != 2'b00) begin
            grants <= grants + 1;
            owner  <= req_ready[1] ? 1 : 0;
        end
        else if (req_done != 2'b00) begin
            dones <= dones + 1;
            owner <= -1;
        end
    end

    // Reference arbitration model.
    int m_last = 1;

    function automatic int model_winner(input logic [1:0] pend);
`ifdef MPC_VSUB_SCHED_FIXED_PRIO_EN
        return pend[0] ? 0 : 1;
`else
        if (pend == 2'b11) return (m_last == 1) ? 0 : 1;
        return pend[0] ? 0 : 1;
`endif
    endfunction

    task automatic randomize_data();
        for (int k = 0; k < 8; k++) begin
            e_rom[k] = $urandom;
            for (int r = 0; r < 2; r++) begin
                case ($urandom_range(0, 5))
                    0:       temp_mem[r][k] = 32'h8000_0000;
                    1:       temp_mem[r][k] = 32'h7FFF_FFFF;
                    default: temp_mem[r][k] = $urandom;
                endcase
            end
        end
    endtask

    task automatic check_row(input int idx, input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_r%0d_f1[%0d]", tag, idx, k), f1_mem[idx][k],
                  sat_sub(e_rom[k], temp_mem[idx][k]));
            f1_mem[idx][k] <= 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_done(output int idx, output int lat);
        idx = -1;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ap_clk);
            lat++;
            if (req_done != 2'b00) begin
                idx = req_done[1] ? 1 : 0;
                return;
            end
        end
        check("done_timeout", {31'd0, req_done != 2'b00}, 32'd1);
    endtask

    task automatic wait_sub_start();
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (sub_start) return;
        end
        check("start_timeout", {31'd0, sub_start}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst    = 1'b1;
        req_start = 2'b00;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        m_last = 1;
    endtask

    task automatic run_pattern(input logic [1:0] pat, input bit rnd, input string tag);
        logic [1:0] pend;
        int exp_q[$];
        int idx, lat, w;
        if (rnd) randomize_data();
        pend = pat;
        while (pend != 2'b00) begin
            w = model_winner(pend);
            exp_q.push_back(w);
            m_last  = w;
            pend[w] = 1'b0;
        end
        req_start = pat;
        foreach (exp_q[j]) begin
            wait_done(idx, lat);
            if (idx < 0) begin
                req_start = 2'b00;
                return;
            end
            check({tag, "_order"}, idx, exp_q[j]);
            check({tag, "_done_onehot"}, {30'd0, req_done}, (exp_q[j] == 1) ? 32'd2 : 32'd1);
            check_row(idx, tag);
            req_start[idx] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, lat, g0, d0, w, gap;

        ap_rst    = 1'b1;
        req_start = 2'b00;
        randomize_data();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++) f1_mem[r][k] <= 32'hDEAD_BEEF;
        #1;
        check("reset_outputs", {20'd0, busy, sub_start, req_ready, req_done, r0_temp_ce0, r0_f1_ce0,
              r0_f1_we0, r1_temp_ce0, r1_f1_ce0, r1_f1_we0}, 32'd0);
        check("reset_q0", sub_temp_q0, 32'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single request with temp = {0..7}: 1-cycle start latency, done 10 cycles later.
        for (int k = 0; k < 8; k++) temp_mem[0][k] = k;
        req_start = 2'b01;
        @(negedge ap_clk);
        check("single_start_lat", {31'd0, sub_start}, 32'd1);
        wait_done(idx, lat);
        check("single_done_lat", lat, 32'd10);
        check("single_done_vec", {30'd0, req_done}, 32'd1);
        if (idx >= 0) check_row(idx, "single");
        req_start = 2'b00;
        m_last    = 0;
        repeat (2) @(negedge ap_clk);

        // Tie held from reset: alternating grants (fixed priority keeps requester 0).
        do_reset();
        randomize_data();
        req_start = 2'b11;
        for (int n = 0; n < 4; n++) begin
            w      = model_winner(2'b11);
            m_last = w;
            wait_done(idx, lat);
            if (idx < 0) break;
            check($sformatf("tie_order%0d", n), idx, w);
            check_row(idx, "tie");
            for (int k = 0; k < 8; k++) temp_mem[idx][k] = $urandom;
            if (n < 3) begin
                gap = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge ap_clk);
                    gap++;
                    if (sub_start) break;
                end
                check($sformatf("tie_gap%0d", n), gap, 32'd2);
            end
        end
        req_start = 2'b00;
        repeat (3) @(negedge ap_clk);

        // Saturation passthrough on requester 1.
        randomize_data();
        e_rom[3]       = 32'h000F_FFFF;
        temp_mem[1][3] = 32'h8000_0000;
        e_rom[5]       = 32'h0000_0000;
        temp_mem[1][5] = 32'h7FFF_FFFF;
        req_start = 2'b10;
        wait_done(idx, lat);
        check("sat_pos", f1_mem[1][3], 32'h7FFF_FFFF);
        check("sat_none", f1_mem[1][5], 32'h8000_0001);
        if (idx >= 0) check_row(idx, "sat");
        req_start = 2'b00;
        m_last    = 1;
        repeat (2) @(negedge ap_clk);

        // Late arrival: r1 joins while r0 runs, is served only afterwards.
        randomize_data();
        g0 = grants;
        req_start = 2'b01;
        wait_sub_start();
        repeat (3) @(negedge ap_clk);
        req_start = 2'b11;
        wait_done(idx, lat);
        check("late_first", idx, 32'd0);
        if (idx >= 0) check_row(idx, "late");
        req_start = 2'b10;
        wait_done(idx, lat);
        check("late_second", idx, 32'd1);
        if (idx >= 0) check_row(idx, "late");
        req_start = 2'b00;
        m_last    = 1;
        check("late_grants", grants - g0, 32'd2);
        repeat (2) @(negedge ap_clk);

        // Reset 4 cycles after sub_start: outputs drop at once, no done.
        randomize_data();
        req_start = 2'b01;
        wait_sub_start();
        repeat (4) @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst_outputs", {20'd0, busy, sub_start, req_ready, req_done, r0_temp_ce0, r0_f1_ce0,
              r0_f1_we0, r1_temp_ce0, r1_f1_ce0, r1_f1_we0}, 32'd0);
        check("midrst_q0", sub_temp_q0, 32'd0);
        d0 = dones;
        req_start = 2'b00;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        m_last = 1;
        repeat (6) @(negedge ap_clk);
        check("midrst_no_done", dones - d0, 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        run_pattern(2'b11, 1'b1, "post_rst");
        repeat (2) @(negedge ap_clk);

        // Abandoned request: a one-cycle r1 pulse while r0 runs is ignored.
        randomize_data();
        req_start = 2'b01;
        wait_sub_start();
        repeat (2) @(negedge ap_clk);
        req_start = 2'b11;
        @(negedge ap_clk);
        req_start = 2'b01;
        wait_done(idx, lat);
        check("aband_first", idx, 32'd0);
        if (idx >= 0) check_row(idx, "aband");
        req_start = 2'b00;
        m_last    = 0;
        g0 = grants;
        repeat (20) @(negedge ap_clk);
        check("aband_no_grant", grants - g0, 32'd0);
        check("aband_idle", {31'd0, busy}, 32'd0);

        // Random request patterns against the model.
        for (int t = 0; t < 8; t++) begin
            run_pattern(2'($urandom_range(1, 3)), 1'b1, $sformatf("rnd%0d", t));
            repeat ($urandom_range(1, 4)) @(negedge ap_clk);
        end

        repeat (3) @(negedge ap_clk);
        check("isolation_violations", viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
